// File: rtl/mc_control_unit_p.sv
// Multicycle MIPS control FSM with configurable memory wait states,
// a mult/div start/done handshake with timeout, and an exception path.
module mc_control_unit_p #(
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned STATE_W    = 5
) (
    input  logic               clock,
    input  logic               Reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               md_done,
    output logic               RstOut,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ALUout,
    output logic               AWrite,
    output logic               BWrite,
    output logic               MDRWrite,
    output logic               EPCWrite,
    output logic               MultCtrl,
    output logic               DivCtrl,
    output logic               ExcFlag,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         RegDst,
    output logic [1:0]         MDRMux,
    output logic [2:0]         IorD,
    output logic [2:0]         PCSrc,
    output logic [2:0]         ALUop,
    output logic [2:0]         ALUSrcB,
    output logic [3:0]         MemToReg,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        RST_S, FETCH, F_WAIT, IR_LD, DECODE,
        EXEC_R, WB_R, EXEC_I, WB_I,
        ADDR, STORE, M_REQ, M_WAIT, M_RD, WB_M,
        BRANCH, JUMP, MD_START, MD_WAIT, EXC
    } state_t;

    localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
    localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);

    localparam logic [5:0] OPC_RTYPE = 6'd0,  OPC_J   = 6'd2;
    localparam logic [5:0] OPC_BEQ   = 6'd4,  OPC_BNE = 6'd5;
    localparam logic [5:0] OPC_ADDI  = 6'd8,  OPC_ADDIU = 6'd9;
    localparam logic [5:0] OPC_LB    = 6'd32, OPC_LH  = 6'd33;
    localparam logic [5:0] OPC_LW    = 6'd35, OPC_SW  = 6'd43;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_MULT = 6'h18, FN_DIV = 6'h1A;

    localparam logic [2:0] IORD_PC = 3'b100, IORD_ALU = 3'b101;
    localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic [7:0] md_cnt;

    logic is_r_alu, is_md, is_imm, is_mem, is_branch;

    assign is_r_alu  = (opcode == OPC_RTYPE) &&
                       (func == FN_ADD || func == FN_SUB || func == FN_AND);
    assign is_md     = (opcode == OPC_RTYPE) && (func == FN_MULT || func == FN_DIV);
    assign is_imm    = (opcode == OPC_ADDI) || (opcode == OPC_ADDIU);
    assign is_mem    = (opcode == OPC_LB) || (opcode == OPC_LH) ||
                       (opcode == OPC_LW) || (opcode == OPC_SW);
    assign is_branch = (opcode == OPC_BEQ) || (opcode == OPC_BNE);

    assign state_dbg = state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state    <= RST_S;
            wait_cnt <= '0;
            md_cnt   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= ((state == F_WAIT || state == M_WAIT) && wait_cnt != WAIT_LAST)
                        ? wait_cnt + 4'd1 : '0;
            md_cnt   <= (state == MD_WAIT) ? md_cnt + 8'd1 : '0;
        end
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        RstOut   = 1'b0;  PCWrite  = 1'b0;  MemWrite = 1'b0;  IRWrite  = 1'b0;
        RegWrite = 1'b0;  ALUout   = 1'b0;  AWrite   = 1'b0;  BWrite   = 1'b0;
        MDRWrite = 1'b0;  EPCWrite = 1'b0;  MultCtrl = 1'b0;  DivCtrl  = 1'b0;
        ExcFlag  = 1'b0;
        ALUSrcA  = 2'b00; RegDst   = 2'b00; MDRMux   = 2'b00;
        IorD     = 3'b000; PCSrc   = 3'b000; ALUop   = 3'b000; ALUSrcB = 3'b000;
        MemToReg = 4'b0000;

        case (state)
            RST_S: begin
                RstOut     = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                IorD       = IORD_PC;
                ALUSrcB    = 3'b001;
                ALUop      = ALU_ADD;
                PCWrite    = 1'b1;
                state_next = HAS_WAIT ? F_WAIT : IR_LD;
            end
            F_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_next = IR_LD;
            end
            IR_LD: begin
                IorD       = IORD_PC;
                IRWrite    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                // Branch target computed speculatively while A/B load.
                AWrite  = 1'b1;
                BWrite  = 1'b1;
                ALUout  = 1'b1;
                ALUSrcB = 3'b011;
                ALUop   = ALU_ADD;
                if (is_r_alu)           state_next = EXEC_R;
                else if (is_md)         state_next = MD_START;
                else if (is_imm)        state_next = EXEC_I;
                else if (is_mem)        state_next = ADDR;
                else if (is_branch)     state_next = BRANCH;
                else if (opcode == OPC_J) state_next = JUMP;
                else                    state_next = EXC;
            end
            EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUout  = 1'b1;
                case (func)
                    FN_SUB:  ALUop = ALU_SUB;
                    FN_AND:  ALUop = ALU_AND;
                    default: ALUop = ALU_ADD;
                endcase
                state_next = WB_R;
            end
            WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b11;
                state_next = FETCH;
            end
            EXEC_I, ADDR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 3'b010;
                ALUop   = ALU_ADD;
                ALUout  = 1'b1;
                if (state == EXEC_I)        state_next = WB_I;
                else if (opcode == OPC_SW)  state_next = STORE;
                else                        state_next = M_REQ;
            end
            WB_I: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            STORE: begin
                IorD       = IORD_ALU;
                MemWrite   = 1'b1;
                state_next = FETCH;
            end
            M_REQ: begin
                IorD       = IORD_ALU;
                state_next = HAS_WAIT ? M_WAIT : M_RD;
            end
            M_WAIT: begin
                IorD = IORD_ALU;
                if (wait_cnt == WAIT_LAST) state_next = M_RD;
            end
            M_RD: begin
                IorD     = IORD_ALU;
                MDRWrite = 1'b1;
                if (opcode == OPC_LB)      MDRMux = 2'b10;
                else if (opcode == OPC_LH) MDRMux = 2'b01;
                else                       MDRMux = 2'b00;
                state_next = WB_M;
            end
            WB_M: begin
                RegWrite   = 1'b1;
                MemToReg   = 4'b0110;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUop      = ALU_SUB;
                PCSrc      = 3'b001;
                PCWrite    = (opcode == OPC_BNE) ? ~zero : zero;
                state_next = FETCH;
            end
            JUMP: begin
                PCSrc      = 3'b010;
                PCWrite    = 1'b1;
                state_next = FETCH;
            end
            MD_START: begin
                MultCtrl   = (func == FN_MULT);
                DivCtrl    = (func == FN_DIV);
                state_next = MD_WAIT;
            end
            MD_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (md_done)                state_next = FETCH;
                else if (md_cnt == MD_LAST) state_next = EXC;
            end
            EXC: begin
                EPCWrite   = 1'b1;
                PCSrc      = 3'b011;
                PCWrite    = 1'b1;
                ExcFlag    = 1'b1;
                state_next = FETCH;
            end
            default: state_next = RST_S;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit_p.sv
// Bench for mc_control_unit_p: three instances (MEM_WAIT 0/1/3) checked
// cycle by cycle against an instruction-level expected-output model.
module tb_mc_control_unit_p;

    typedef struct packed {
        logic       rstout, pcwrite, memwrite, irwrite, regwrite, aluout, awrite;
        logic       bwrite, mdrwrite, epcwrite, multctrl, divctrl, excflag;
        logic [1:0] alusrca, regdst, mdrmux;
        logic [2:0] iord, pcsrc, aluop, alusrcb;
        logic [3:0] memtoreg;
    } outs_t;

    localparam int N = 3;
    localparam int W_OF [N] = '{0, 1, 3};
    localparam int TMO = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_v  [N];
    logic [5:0] op_v   [N];
    logic [5:0] fn_v   [N];
    logic       zero_v [N];
    logic       done_v [N];
    outs_t      obs    [N];
    logic [4:0] sdbg   [N];

    int total = 0;
    int bad   = 0;

    outs_t exp_q [$];
    outs_t obs_q [$];
    outs_t rq    [$];
    logic  zero_q [$];
    logic [4:0] rst_dbg;
    logic [4:0] sdbg_rst [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic       rstout, pcwrite, memwrite, irwrite, regwrite, aluout, awrite;
        logic       bwrite, mdrwrite, epcwrite, multctrl, divctrl, excflag;
        logic [1:0] alusrca, regdst, mdrmux;
        logic [2:0] iord, pcsrc, aluop, alusrcb;
        logic [3:0] memtoreg;
        logic [4:0] state_dbg;

        mc_control_unit_p #(.MEM_WAIT(W_OF[g]), .MD_TIMEOUT(TMO), .STATE_W(5)) u_dut (
            .clock(clock), .Reset(rst_v[g]), .opcode(op_v[g]), .func(fn_v[g]),
            .zero(zero_v[g]), .md_done(done_v[g]),
            .RstOut(rstout), .PCWrite(pcwrite), .MemWrite(memwrite), .IRWrite(irwrite),
            .RegWrite(regwrite), .ALUout(aluout), .AWrite(awrite), .BWrite(bwrite),
            .MDRWrite(mdrwrite), .EPCWrite(epcwrite), .MultCtrl(multctrl),
            .DivCtrl(divctrl), .ExcFlag(excflag), .ALUSrcA(alusrca), .RegDst(regdst),
            .MDRMux(mdrmux), .IorD(iord), .PCSrc(pcsrc), .ALUop(aluop),
            .ALUSrcB(alusrcb), .MemToReg(memtoreg), .state_dbg(state_dbg)
        );

        assign obs[g]  = {rstout, pcwrite, memwrite, irwrite, regwrite, aluout, awrite,
                          bwrite, mdrwrite, epcwrite, multctrl, divctrl, excflag,
                          alusrca, regdst, mdrmux, iord, pcsrc, aluop, alusrcb, memtoreg};
        assign sdbg[g] = state_dbg;
    end

    // Expected per-cycle outputs of one instruction, starting at its fetch.
    // done_at: MD_WAIT cycle (1-based) on which md_done rises, 0 = never.
    task automatic build_seq(input int w, input logic [5:0] op, input logic [5:0] fn,
                             input int done_at, output int br_idx, output int done_idx);
        outs_t e;
        bit r_alu, md, imm, ld, st, br, jmp, in_time;
        int nwait;
        r_alu = (op == 0) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        md    = (op == 0) && (fn == 6'h18 || fn == 6'h1A);
        imm   = (op == 8) || (op == 9);
        ld    = (op == 32) || (op == 33) || (op == 35);
        st    = (op == 43);
        br    = (op == 4) || (op == 5);
        jmp   = (op == 2);
        br_idx = -1;
        done_idx = -1;
        exp_q.delete();

        e = '0; e.iord = 3'b100; e.alusrcb = 3'b001; e.aluop = 3'b001; e.pcwrite = 1'b1;
        exp_q.push_back(e);
        repeat (w) exp_q.push_back('0);
        e = '0; e.iord = 3'b100; e.irwrite = 1'b1;
        exp_q.push_back(e);
        e = '0; e.awrite = 1'b1; e.bwrite = 1'b1; e.aluout = 1'b1;
        e.alusrcb = 3'b011; e.aluop = 3'b001;
        exp_q.push_back(e);

        if (r_alu) begin
            e = '0; e.alusrca = 2'b10; e.aluout = 1'b1;
            e.aluop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            exp_q.push_back(e);
            e = '0; e.regwrite = 1'b1; e.regdst = 2'b11;
            exp_q.push_back(e);
        end else if (imm || ld || st) begin
            e = '0; e.alusrca = 2'b10; e.alusrcb = 3'b010; e.aluop = 3'b001; e.aluout = 1'b1;
            exp_q.push_back(e);
            if (imm) begin
                e = '0; e.regwrite = 1'b1;
                exp_q.push_back(e);
            end else if (st) begin
                e = '0; e.iord = 3'b101; e.memwrite = 1'b1;
                exp_q.push_back(e);
            end else begin
                e = '0; e.iord = 3'b101;
                repeat (w + 1) exp_q.push_back(e);
                e.mdrwrite = 1'b1;
                e.mdrmux = (op == 32) ? 2'b10 : (op == 33) ? 2'b01 : 2'b00;
                exp_q.push_back(e);
                e = '0; e.regwrite = 1'b1; e.memtoreg = 4'b0110;
                exp_q.push_back(e);
            end
        end else if (br) begin
            br_idx = exp_q.size();
            e = '0; e.alusrca = 2'b10; e.aluop = 3'b010; e.pcsrc = 3'b001;
            exp_q.push_back(e);
        end else if (jmp) begin
            e = '0; e.pcsrc = 3'b010; e.pcwrite = 1'b1;
            exp_q.push_back(e);
        end else if (md) begin
            e = '0; e.multctrl = (fn == 6'h18); e.divctrl = (fn == 6'h1A);
            exp_q.push_back(e);
            in_time = (done_at >= 1) && (done_at <= TMO);
            nwait = in_time ? done_at : TMO;
            if (done_at >= 1) done_idx = exp_q.size() + done_at - 1;
            repeat (nwait) exp_q.push_back('0);
            if (!in_time) begin
                e = '0; e.epcwrite = 1'b1; e.pcsrc = 3'b011; e.pcwrite = 1'b1; e.excflag = 1'b1;
                exp_q.push_back(e);
            end
        end else begin
            e = '0; e.epcwrite = 1'b1; e.pcsrc = 3'b011; e.pcwrite = 1'b1; e.excflag = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Drives n cycles of one instruction on instance k and records outputs.
    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                             input int n, input int done_idx, input bit rand_done,
                             input int zmode);
        obs_q.delete();
        zero_q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) begin
                op_v[k] = op;
                fn_v[k] = fn;
            end
            zero_v[k] = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            done_v[k] = (i == done_idx) ? 1'b1
                      : (rand_done ? 1'($urandom_range(0, 1)) : 1'b0);
            zero_q.push_back(zero_v[k]);
            @(negedge clock);
            obs_q.push_back(obs[k]);
        end
    endtask

    task automatic exec(input int k, input logic [5:0] op, input logic [5:0] fn,
                        input int done_at, input int zmode);
        int br_idx, done_idx;
        bit md;
        build_seq(W_OF[k], op, fn, done_at, br_idx, done_idx);
        md = (op == 0) && (fn == 6'h18 || fn == 6'h1A);
        run_instr(k, op, fn, exp_q.size(), done_idx, !md, zmode);
        if (br_idx >= 0)
            exp_q[br_idx].pcwrite = (op == 6'd4) ? zero_q[br_idx] : ~zero_q[br_idx];
    endtask

    // Holds reset for 'hold' cycles, releases it, records through the RST_S cycle.
    task automatic reset_inst(input int k, input int hold);
        rq.delete();
        @(posedge clock);
        #1 rst_v[k] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i > 0) @(posedge clock);
            @(negedge clock);
            rq.push_back(obs[k]);
            rst_dbg = sdbg[k];
        end
        @(posedge clock);
        #1 rst_v[k] = 1'b0;
        @(negedge clock);
        rq.push_back(obs[k]);
    endtask

    task automatic test_reset();
        outs_t e;
        e = '0; e.rstout = 1'b1;
        for (int k = 0; k < N; k++) begin
            reset_inst(k, 3);
            sdbg_rst[k] = rst_dbg;
            foreach (rq[i]) begin
                total++;
                if (rq[i] !== e) begin
                    bad++;
                    $display("FAIL reset inst%0d cyc %0d: got %h want %h", k, i, rq[i], e);
                end
            end
            exec(k, 6'd0, 6'h20, 0, -1);
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL post_reset_add inst%0d cyc %0d: got %h want %h",
                             k, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_alu();
        logic [5:0] ops [6] = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd9, 6'd0};
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h00, 6'h3F, 6'h20};
        reset_inst(1, 1);
        for (int t = 0; t < 6; t++) begin
            exec(1, ops[t], fns[t], 0, -1);
            total++;
            if (obs_q.size() != 5 + W_OF[1]) begin
                bad++;
                $display("FAIL alu_latency op %0d: got %0d want %0d", ops[t], obs_q.size(), 5 + W_OF[1]);
            end
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL alu op %0d fn %h cyc %0d: got %h want %h",
                             ops[t], fns[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [5:0] ops [6] = '{6'd33, 6'd32, 6'd35, 6'd43, 6'd33, 6'd0};
        reset_inst(2, 1);
        for (int t = 0; t < 6; t++) begin
            exec(2, ops[t], (ops[t] == 0) ? 6'h20 : 6'h00, 0, -1);
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL ldst op %0d cyc %0d: got %h want %h", ops[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [5] = '{6'd4, 6'd4, 6'd5, 6'd5, 6'd2};
        int         zs  [5] = '{1, 0, 1, 0, 0};
        for (int k = 0; k < 2; k++) begin
            reset_inst(k, 1);
            for (int t = 0; t < 5; t++) begin
                exec(k, ops[t], 6'h00, 0, zs[t]);
                foreach (exp_q[i]) begin
                    total++;
                    if (obs_q[i] !== exp_q[i]) begin
                        bad++;
                        $display("FAIL branch inst%0d op %0d z %0d cyc %0d: got %h want %h",
                                 k, ops[t], zs[t], i, obs_q[i], exp_q[i]);
                    end
                end
            end
            exec(k, 6'd8, 6'h00, 0, -1);
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL branch_after inst%0d cyc %0d: got %h want %h", k, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_md();
        logic [5:0] fns [6] = '{6'h1A, 6'h1A, 6'h18, 6'h18, 6'h1A, 6'h18};
        int         dat [6] = '{0, 8, 1, 3, 9, 7};
        reset_inst(1, 1);
        for (int t = 0; t < 6; t++) begin
            exec(1, 6'd0, fns[t], dat[t], -1);
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL md fn %h done_at %0d cyc %0d: got %h want %h",
                             fns[t], dat[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
        exec(1, 6'd0, 6'h22, 0, -1);
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL md_after cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [4] = '{6'd63, 6'd0, 6'd1, 6'd0};
        logic [5:0] fns [4] = '{6'h00, 6'h21, 6'h00, 6'h24};
        reset_inst(0, 1);
        for (int t = 0; t < 4; t++) begin
            exec(0, ops[t], fns[t], 0, -1);
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL illegal op %0d fn %h cyc %0d: got %h want %h",
                             ops[t], fns[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int br_idx, done_idx;
        outs_t e;
        reset_inst(2, 1);
        // Fetch(1) + F_WAIT(3) + IR_LD + DECODE + ADDR + M_REQ + first M_WAIT = 9 cycles.
        build_seq(W_OF[2], 6'd35, 6'h00, 0, br_idx, done_idx);
        run_instr(2, 6'd35, 6'h00, 9, -1, 1'b1, -1);
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        reset_inst(2, 2);
        e = '0; e.rstout = 1'b1;
        foreach (rq[i]) begin
            total++;
            if (rq[i] !== e) begin
                bad++;
                $display("FAIL reset_mid cyc %0d: got %h want %h", i, rq[i], e);
            end
        end
        total++;
        if (rst_dbg !== sdbg_rst[2]) begin
            bad++;
            $display("FAIL reset_mid_state: got %h want %h", rst_dbg, sdbg_rst[2]);
        end
        exec(2, 6'd35, 6'h00, 0, -1);
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_mid_post cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [15] = '{0, 0, 0, 0, 0, 8, 9, 32, 33, 35, 43, 4, 5, 2, 0};
        logic [5:0] fns [15] = '{6'h20, 6'h22, 6'h24, 6'h18, 6'h1A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00};
        logic [5:0] op, fn;
        int sel, dat;
        for (int k = 0; k < N; k++) begin
            reset_inst(k, 1);
            for (int t = 0; t < 25; t++) begin
                sel = $urandom_range(0, 15);
                if (sel == 15) begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                end else begin
                    op = ops[sel];
                    fn = fns[sel];
                end
                dat = $urandom_range(0, TMO + 2);
                exec(k, op, fn, dat, -1);
                foreach (exp_q[i]) begin
                    total++;
                    if (obs_q[i] !== exp_q[i]) begin
                        bad++;
                        $display("FAIL b2b inst%0d op %0d fn %h done_at %0d cyc %0d: got %h want %h",
                                 k, op, fn, dat, i, obs_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_v[k]  = 1'b1;
            op_v[k]   = '0;
            fn_v[k]   = '0;
            zero_v[k] = 1'b0;
            done_v[k] = 1'b0;
        end
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_md();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
